// File: rtl/arbitro_rr_8.sv
// arbitro_rr_8: round-robin arbiter for eight requesters sharing one 8x1 mux.
// Three-state FSM (IDLE -> GRANT -> GAP -> IDLE) with fully registered outputs.
// Optional forced release of a long-held grant is built when the macro
// ARB_TIMEOUT_EN is defined; TIMEOUT then sets the maximum GRANT length.
module arbitro_rr_8 #(
  parameter int TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       ativo,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Reject out-of-range TIMEOUT values at elaboration.
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("arbitro_rr_8: TIMEOUT must be in 2..255");
  end

  state_t     r_state, w_state_next;
  logic [7:0] r_grant, w_grant_next;
  logic [2:0] r_sel, w_sel_next;
  logic       r_ativo, w_ativo_next;
  logic       r_timeout, w_timeout_next;
  logic [2:0] r_ultimo, w_ultimo_next;
`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_cnt, w_cnt_next;
`endif

  // Requests rotated so bit k is requester (ultimo+1+k) mod 8; the lowest set
  // bit of this vector is the round-robin winner.
  logic [7:0] w_rot;
  logic [2:0] w_off;
  logic [2:0] w_winner;

  for (genvar gi = 0; gi < 8; gi++) begin : g_rot
    assign w_rot[gi] = req[3'(r_ultimo + 3'(gi + 1))];
  end

  // Priority-encode the rotated vector (lowest index wins).
  always_comb begin
    w_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_rot[i]) w_off = 3'(i);
    end
  end

  assign w_winner = r_ultimo + 3'd1 + w_off;

  // Next-state and next-output logic; everything lands in registers below.
  always_comb begin
    w_state_next   = r_state;
    w_grant_next   = r_grant;
    w_sel_next     = r_sel;
    w_ativo_next   = r_ativo;
    w_timeout_next = 1'b0;
    w_ultimo_next  = r_ultimo;
`ifdef ARB_TIMEOUT_EN
    w_cnt_next     = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        w_grant_next = 8'd0;
        w_ativo_next = 1'b0;
        if (|req) begin
          w_state_next  = S_GRANT;
          w_sel_next    = w_winner;
          w_grant_next  = 8'd1 << w_winner;
          w_ativo_next  = 1'b1;
          w_ultimo_next = w_winner;
`ifdef ARB_TIMEOUT_EN
          w_cnt_next    = 8'd0;
`endif
        end
      end
      S_GRANT: begin
        if (!req[r_sel]) begin
          // Voluntary release wins over a coincident timeout.
          w_state_next = S_GAP;
          w_grant_next = 8'd0;
          w_ativo_next = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_cnt == 8'(TIMEOUT - 1)) begin
          // Forced release; ultimo keeps the preempted index so it goes last.
          w_state_next   = S_GAP;
          w_grant_next   = 8'd0;
          w_ativo_next   = 1'b0;
          w_timeout_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
`endif
      end
      S_GAP: begin
        w_state_next = S_IDLE;
        w_grant_next = 8'd0;
        w_ativo_next = 1'b0;
      end
      default: begin
        w_state_next = S_IDLE;
        w_grant_next = 8'd0;
        w_ativo_next = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_grant   <= 8'd0;
      r_sel     <= 3'd0;
      r_ativo   <= 1'b0;
      r_timeout <= 1'b0;
      r_ultimo  <= 3'd7;
`ifdef ARB_TIMEOUT_EN
      r_cnt     <= 8'd0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_grant   <= w_grant_next;
      r_sel     <= w_sel_next;
      r_ativo   <= w_ativo_next;
      r_timeout <= w_timeout_next;
      r_ultimo  <= w_ultimo_next;
`ifdef ARB_TIMEOUT_EN
      r_cnt     <= w_cnt_next;
`endif
    end
  end

  assign grant   = r_grant;
  assign sel     = r_sel;
  assign ativo   = r_ativo;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_arbitro_rr_8.sv
// tb_arbitro_rr_8: directed literal checks plus randomized traffic compared
// every cycle against a behavioural round-robin model.
module tb_arbitro_rr_8;

  localparam int TO = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req   = 8'd0;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       ativo;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  arbitro_rr_8 #(.TIMEOUT(TO)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .grant   (grant),
    .sel     (sel),
    .ativo   (ativo),
    .timeout (timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: phase 0=waiting, 1=owner holds the mux, 2=dead cycle.
  bit       m_valid = 0;
  int       m_phase = 0;
  int       m_owner = 0;
  int       m_last  = 7;
  int       m_held  = 0;
  bit       m_to    = 0;
  bit       m_en_to;

  initial begin
`ifdef ARB_TIMEOUT_EN
    m_en_to = 1;
`else
    m_en_to = 0;
`endif
  end

  always @(posedge clock) begin
    if (reset) begin
      m_phase = 0; m_owner = 0; m_last = 7; m_held = 0; m_to = 0; m_valid = 1;
    end else if (m_phase == 0) begin
      if (req != 8'd0) begin
        for (int k = 1; k <= 8; k++) begin
          if (req[(m_last + k) % 8]) begin
            m_owner = (m_last + k) % 8;
            break;
          end
        end
        m_last  = m_owner;
        m_phase = 1;
        m_held  = 1;
      end
    end else if (m_phase == 1) begin
      if (!req[m_owner]) begin
        m_phase = 2; m_to = 0;
      end else if (m_en_to && m_held == TO) begin
        m_phase = 2; m_to = 1;
      end else begin
        m_held++;
      end
    end else begin
      m_phase = 0; m_to = 0;
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clock) begin
    if (m_valid) begin
      chk("model_grant", {24'd0, grant}, (m_phase == 1) ? (32'd1 << m_owner) : 32'd0);
      chk("model_sel", {29'd0, sel}, 32'(m_owner));
      chk("model_ativo", {31'd0, ativo}, {31'd0, m_phase == 1});
      chk("model_timeout", {31'd0, timeout}, {31'd0, (m_phase == 2) && m_to});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] oh;
    int exp_s;

    // Reset state
    reset = 1'b1; req = 8'd0;
    tick(); tick();
    chk("rst_grant", {24'd0, grant}, 32'h0);
    chk("rst_sel", {29'd0, sel}, 32'd0);
    chk("rst_ativo", {31'd0, ativo}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    reset = 1'b0;

    // Two requesters: lowest wins first, then the other after GAP + IDLE
    req = 8'b0010_0100;
    tick();
    chk("first_grant", {24'd0, grant}, 32'h04);
    chk("first_sel", {29'd0, sel}, 32'd2);
    tick(); tick();
    chk("hold_grant", {24'd0, grant}, 32'h04);
    req = 8'b0010_0000;
    tick();
    chk("gap_ativo", {31'd0, ativo}, 32'd0);
    chk("gap_sel", {29'd0, sel}, 32'd2);
    tick();
    chk("idle_ativo", {31'd0, ativo}, 32'd0);
    tick();
    chk("second_grant", {24'd0, grant}, 32'h20);
    chk("second_sel", {29'd0, sel}, 32'd5);
    req = 8'd0;
    tick(); tick();

    // Reset in the middle of a grant
    req = 8'b0000_1000;
    tick();
    chk("pre_rst_sel", {29'd0, sel}, 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_grant", {24'd0, grant}, 32'h0);
    chk("midrst_sel", {29'd0, sel}, 32'd0);
    chk("midrst_ativo", {31'd0, ativo}, 32'd0);
    tick();
    chk("postrst_grant", {24'd0, grant}, 32'h08);
    req = 8'd0;
    tick(); tick();

    // Owner 6 releases; request re-pulsed only during GAP is lost
    req = 8'b0100_0000;
    tick();
    chk("own6_grant", {24'd0, grant}, 32'h40);
    req = 8'd0;
    tick();
    req = 8'b0100_0000;
    tick();
    req = 8'd0;
    chk("lost_ativo0", {31'd0, ativo}, 32'd0);
    tick();
    chk("lost_ativo1", {31'd0, ativo}, 32'd0);
    chk("lost_grant", {24'd0, grant}, 32'h0);
    tick();
    chk("lost_ativo2", {31'd0, ativo}, 32'd0);

    // All requesting; each owner releases after 3 cycles. Last owner was 6.
    req = 8'hFF;
    tick();
    for (int n = 0; n < 9; n++) begin
      exp_s = (7 + n) % 8;
      oh = 8'd1 << exp_s;
      chk("rot_sel", {29'd0, sel}, 32'(exp_s));
      chk("rot_grant", {24'd0, grant}, {24'd0, oh});
      tick(); tick();
      req = 8'hFF & ~oh;
      tick();
      chk("rot_gap", {31'd0, ativo}, 32'd0);
      req = 8'hFF;
      tick();
      chk("rot_idle", {31'd0, ativo}, 32'd0);
      tick();
    end
    req = 8'd0;
    tick(); tick(); tick();

`ifdef ARB_TIMEOUT_EN
    // Two holders alternate under forced release
    reset = 1'b1; tick(); reset = 1'b0;
    req = 8'b0000_0011;
    tick();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < TO; c++) begin
        chk("to_sel", {29'd0, sel}, 32'(r % 2));
        chk("to_ativo", {31'd0, ativo}, 32'd1);
        tick();
      end
      chk("to_pulse", {31'd0, timeout}, 32'd1);
      tick();
      chk("to_pulse_end", {31'd0, timeout}, 32'd0);
      tick();
    end
    req = 8'd0;
    tick(); tick(); tick();
`else
    // Sole holder keeps the grant indefinitely
    reset = 1'b1; tick(); reset = 1'b0;
    req = 8'b0000_0001;
    tick();
    for (int c = 0; c < 100; c++) begin
      chk("long_grant", {24'd0, grant}, 32'h01);
      chk("long_timeout", {31'd0, timeout}, 32'd0);
      tick();
    end
    req = 8'd0;
    tick(); tick(); tick();
`endif

    // Randomized traffic; the model compare process does the checking
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 5))
        0: req = 8'($urandom);
        1: req = 8'($urandom) & 8'($urandom) & 8'($urandom);
        2: if (ativo) req[sel] = 1'b0;
        3: req = 8'd0;
        default: ;
      endcase
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arbitro_rr_8.md
ARBITRO_RR_8 -- requirements
Module: arbitro_rr_8

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, giving the maximum consecutive GRANT cycles per owner (range 2..255, only used with ARB_TIMEOUT_EN).
REQ-002 The block SHALL have port clock, input, 1 bit, the single clock; every register updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port req, input, 8 bits; req[i]=1 means requester i wants the shared 8x1 multiplexer.
REQ-005 The block SHALL have port grant, output, 8 bits; it is one-hot while ativo=1 and all-zero otherwise.
REQ-006 The block SHALL have port sel, output, 3 bits; it drives SEL of the shared 8x1 multiplexer.
REQ-007 The block SHALL have port ativo, output, 1 bit; it is 1 exactly in state GRANT.
REQ-008 The block SHALL have port timeout, output, 1 bit; it is a one-cycle pulse on forced release.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, GRANT and GAP; all outputs are registered.
REQ-010 In IDLE with req=0, the block SHALL stay in IDLE with grant=0 and sel holding its last value.
REQ-011 In IDLE with req!=0, the block SHALL enter GRANT on the next edge, so grant is visible 1 cycle after req is sampled.
REQ-012 The winner SHALL be the first set bit of req searched in order ultimo+1, ultimo+2, ..., ultimo+8 (mod 8), where ultimo is an internal 3-bit pointer of the last owner.
REQ-013 On entry to GRANT the block SHALL set sel=winner, grant=1<<winner and ultimo=winner in the same edge.
REQ-014 In GRANT the block SHALL hold sel and grant constant while req[sel]=1; req changes on other bits SHALL be ignored.
REQ-015 In GRANT when req[sel]=0 is sampled, the block SHALL move to GAP on that edge.
REQ-016 GAP SHALL last exactly 1 cycle with grant=0, ativo=0 and sel unchanged, then return to IDLE; a pending request is therefore re-granted no earlier than 2 cycles after release.
REQ-017 The sole requester SHALL win repeatedly; with all 8 requesting continuously, grants SHALL rotate 0,1,...,7,0 with no index skipped.
REQ-018 A req pulse that is deasserted before it is sampled in IDLE SHALL be lost; the block does not latch requests.

Reset
REQ-019 With reset=1 at an edge, the block SHALL go to IDLE with grant=0, sel=0, ativo=0, timeout=0, ultimo=7 and the timeout counter at 0, overriding every other input including mid-GRANT.
REQ-020 The first grant after reset SHALL go to the lowest-indexed active requester.

Configuration
REQ-021 With macro ARB_TIMEOUT_EN defined, a counter SHALL clear on GRANT entry and increment each GRANT cycle.
REQ-022 With ARB_TIMEOUT_EN defined, when the counter equals TIMEOUT-1 while req[sel]=1, the block SHALL move to GAP and pulse timeout=1 for the GAP cycle; ultimo keeps the preempted index, so the preempted requester is served after the others.
REQ-023 With ARB_TIMEOUT_EN defined and release and timeout on the same edge, release SHALL take precedence and timeout SHALL stay 0.
REQ-024 Without ARB_TIMEOUT_EN, there SHALL be no counter, timeout SHALL be constant 0, TIMEOUT SHALL be ignored, and grants SHALL last indefinitely.

Verification
REQ-025 Reset then req=8'b0010_0100 held -> grant=8'b0000_0100, sel=2 one cycle later; drop req[2] -> one GAP cycle, then IDLE, then grant=8'b0010_0000, sel=5.
REQ-026 req=8'hFF held, each owner releases after 3 cycles -> sel sequence 0,1,2,...,7,0 with exactly 1 GAP and 1 IDLE cycle between grants.
REQ-027 With sel=3 granted, assert reset for 1 cycle -> next cycle grant=0, sel=0, ativo=0; with req=8'b0000_1000 still high -> grant=8'b0000_1000 after the IDLE cycle.
REQ-028 With ARB_TIMEOUT_EN, TIMEOUT=4, req=8'b0000_0011 held -> sel=0 for 4 cycles, timeout pulse, then sel=1 for 4 cycles, alternating.
REQ-029 Without ARB_TIMEOUT_EN, req=8'b0000_0001 held for 100 cycles -> grant stays 8'b0000_0001 and timeout stays 0 throughout.
REQ-030 Owner 6 releases while req[6] is re-pulsed only during GAP -> no grant is issued, and the block stays in IDLE.
